// File: rtl/bus_arbiter.sv
// Four-requester bus arbiter: round-robin grant with burst limit and a one-cycle turnaround between owners.
// Latency: a request sampled at an edge is granted at that edge (1 cycle request-to-grant); TURN adds 1 idle cycle.
// Backpressure: requesters hold req until granted; an owner keeps the bus while requesting, up to BURST_MAX cycles under contention.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   req      - request vector; bit 0 is the CPU datapath transceiver/address path
//   gnt      - registered one-hot grant, all-zero when the bus has no owner
//   gnt_id   - index of the current owner, meaningful only while bus_busy=1
//   bus_busy - high while any gnt bit is high
//   preempt  - one-cycle pulse during the turnaround that follows a burst-limit preemption
//
// Optional feature: define ARB_CPU_PRIORITY_EN to make requester 0 win every arbitration
// it takes part in and to make it immune to preemption. Default build is pure round-robin.
module bus_arbiter #(
  parameter int NREQ      = 4,   // informational; the datapath is fixed at four requesters
  parameter int BURST_MAX = 16   // 2..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       bus_busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(BURST_MAX - 1);

  state_t     state, nxt_state;
  logic [3:0] nxt_gnt;
  logic [1:0] nxt_id;
  logic [1:0] last_owner, nxt_last;
  logic [7:0] cnt, nxt_cnt;
  logic       nxt_preempt;

  logic [1:0] win_id;
  logic [1:0] idx;
  logic       others;
  logic       may_preempt;

  // Round-robin search from last_owner+1. Scanning from the far end and
  // overwriting leaves the nearest active requester in win_id.
  always_comb begin : arbitrate
    win_id = last_owner;
    idx    = last_owner;
    for (int i = NREQ; i >= 1; i--) begin
      idx = last_owner + 2'(i);
      if (req[idx]) win_id = idx;
    end
`ifdef ARB_CPU_PRIORITY_EN
    if (req[0]) win_id = 2'd0;
`endif
  end

  // In GRANT, gnt is the owner's one-hot, so masking it leaves the competitors.
  assign others = |(req & ~gnt);

`ifdef ARB_CPU_PRIORITY_EN
  assign may_preempt = (gnt_id != 2'd0);
`else
  assign may_preempt = 1'b1;
`endif

  always_comb begin : next_state_logic
    nxt_state   = state;
    nxt_gnt     = gnt;
    nxt_id      = gnt_id;
    nxt_cnt     = cnt;
    nxt_last    = last_owner;
    nxt_preempt = 1'b0;
    case (state)
      GRANT: begin
        if (!req[gnt_id]) begin
          // voluntary release
          nxt_state = TURN;
          nxt_gnt   = '0;
          nxt_cnt   = '0;
        end else if (cnt == CNT_MAX && others && may_preempt) begin
          nxt_state   = TURN;
          nxt_gnt     = '0;
          nxt_cnt     = '0;
          nxt_preempt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          nxt_cnt = cnt + 8'd1;
        end
        // saturated with no competitor: owner keeps the bus
      end
      default: begin
        // IDLE and TURN arbitrate identically; TURN only guarantees the dead cycle
        nxt_cnt = '0;
        if (|req) begin
          nxt_state = GRANT;
          nxt_gnt   = 4'b0001 << win_id;
          nxt_id    = win_id;
          nxt_last  = win_id;
        end else begin
          nxt_state = IDLE;
          nxt_gnt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      cnt        <= '0;
      last_owner <= 2'd3;   // first arbitration after reset starts at requester 0
      preempt    <= 1'b0;
    end else begin
      state      <= nxt_state;
      gnt        <= nxt_gnt;
      gnt_id     <= nxt_id;
      cnt        <= nxt_cnt;
      last_owner <= nxt_last;
      preempt    <= nxt_preempt;
    end
  end

  assign bus_busy = |gnt;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int BM = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_busy;
  logic       preempt;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: who owns the bus, for how long, and who owned it last
  int         m_owner;
  int         m_last;
  int         m_run;
  logic       m_pre;
  logic [3:0] e_gnt;

  bus_arbiter #(.NREQ(4), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .bus_busy(bus_busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_run = 0; m_pre = 1'b0; e_gnt = 4'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int   pick;
    logic can_lose;
    m_pre = 1'b0;
    pick  = -1;
    if (m_owner >= 0) begin
`ifdef ARB_CPU_PRIORITY_EN
      can_lose = (m_owner != 0);
`else
      can_lose = 1'b1;
`endif
      if (!r[m_owner]) m_owner = -1;
      else if (m_run >= BM && (r & ~4'(1 << m_owner)) != 4'b0 && can_lose) begin
        m_owner = -1; m_pre = 1'b1;
      end else m_run++;
    end else if (r != 4'b0) begin
`ifdef ARB_CPU_PRIORITY_EN
      if (r[0]) pick = 0;
`endif
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
      m_owner = pick; m_last = pick; m_run = 1;
    end
    e_gnt = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b0;
    #3;
    model_reset();
    n_checks++;
    if ({gnt, gnt_id, bus_busy, preempt} !== 8'b0)
      $display("FAIL reset_state: got gnt=%b id=%0d busy=%b pre=%b want all 0", gnt, gnt_id, bus_busy, preempt);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] pat[3] = '{4'b0001, 4'b0000, 4'b0000};
    test_reset();
    for (int c = 0; c < 3; c++) begin
      step(pat[c]);
      n_checks++;
      if ({gnt, bus_busy, preempt} !== {e_gnt, e_gnt != 4'b0, m_pre})
        $display("FAIL single cyc %0d: gnt/busy/pre got %b/%b/%b want %b/%b/%b", c, gnt, bus_busy, preempt, e_gnt, e_gnt != 4'b0, m_pre);
      else n_pass++;
      if (e_gnt != 4'b0) begin
        n_checks++;
        if (gnt_id !== 2'(m_owner)) $display("FAIL single_id cyc %0d: got %0d want %0d", c, gnt_id, m_owner);
        else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    int         starts[$];
    int         exp_order[$];
    int         npre = 0;
    int         exp_pre;
    logic [3:0] prev = 4'b0;
    test_reset();
    for (int c = 0; c < 25; c++) begin
      step(4'hF);
      n_checks++;
      if ({gnt, bus_busy, preempt} !== {e_gnt, e_gnt != 4'b0, m_pre})
        $display("FAIL rr cyc %0d: gnt/busy/pre got %b/%b/%b want %b/%b/%b", c, gnt, bus_busy, preempt, e_gnt, e_gnt != 4'b0, m_pre);
      else n_pass++;
      if (e_gnt != 4'b0) begin
        n_checks++;
        if (gnt_id !== 2'(m_owner)) $display("FAIL rr_id cyc %0d: got %0d want %0d", c, gnt_id, m_owner);
        else n_pass++;
      end
      if (gnt != 4'b0 && prev == 4'b0) starts.push_back(int'(gnt_id));
      if (preempt) npre++;
      prev = gnt;
    end
`ifdef ARB_CPU_PRIORITY_EN
    exp_order = '{0};
    exp_pre   = 0;
`else
    exp_order = '{0, 1, 2, 3, 0};
    exp_pre   = 5;
`endif
    n_checks++;
    if (starts.size() != exp_order.size())
      $display("FAIL rr_order_len: got %0d grants want %0d", starts.size(), exp_order.size());
    else n_pass++;
    for (int i = 0; i < exp_order.size() && i < starts.size(); i++) begin
      n_checks++;
      if (starts[i] != exp_order[i]) $display("FAIL rr_order[%0d]: got %0d want %0d", i, starts[i], exp_order[i]);
      else n_pass++;
    end
    n_checks++;
    if (npre != exp_pre) $display("FAIL rr_preempt_count: got %0d want %0d", npre, exp_pre);
    else n_pass++;
  endtask

  task automatic test_hold();
    int npre = 0;
    test_reset();
    for (int c = 0; c < 40; c++) begin
      step(4'b0100);
      n_checks++;
      if ({gnt, bus_busy, preempt} !== {e_gnt, e_gnt != 4'b0, m_pre})
        $display("FAIL hold cyc %0d: gnt/busy/pre got %b/%b/%b want %b/%b/%b", c, gnt, bus_busy, preempt, e_gnt, e_gnt != 4'b0, m_pre);
      else n_pass++;
      if (preempt) npre++;
    end
    n_checks++;
    if (npre != 0 || gnt !== 4'b0100) $display("FAIL hold_end: preempts=%0d gnt=%b want 0 and 0100", npre, gnt);
    else n_pass++;
  endtask

  task automatic test_release();
    logic [3:0] want;
    logic [3:0] pat[3] = '{4'b0100, 4'b1001, 4'b1001};
    test_reset();
    for (int c = 0; c < 3; c++) begin
      step(pat[c]);
      n_checks++;
      if ({gnt, bus_busy, preempt} !== {e_gnt, e_gnt != 4'b0, m_pre})
        $display("FAIL release cyc %0d: gnt/busy/pre got %b/%b/%b want %b/%b/%b", c, gnt, bus_busy, preempt, e_gnt, e_gnt != 4'b0, m_pre);
      else n_pass++;
    end
`ifdef ARB_CPU_PRIORITY_EN
    want = 4'b0001;
`else
    want = 4'b1000;
`endif
    n_checks++;
    if (gnt !== want) $display("FAIL release_winner: got %b want %b", gnt, want);
    else n_pass++;
  endtask

  task automatic test_glitch();
    test_reset();
    @(negedge clk);
    req = 4'b0010;
    #2;
    req = 4'b0000;
    @(posedge clk);
    model_step(4'b0000);
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || bus_busy !== 1'b0) $display("FAIL glitch: got gnt=%b busy=%b want 0000/0", gnt, bus_busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    test_reset();
    step(4'b0010);
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL areset_pre: got %b want 0010", gnt);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (gnt !== 4'b0000 || bus_busy !== 1'b0) $display("FAIL areset_drop: got gnt=%b busy=%b want 0000/0", gnt, bus_busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0010;
    @(posedge clk);
    model_step(4'b0010);
    #1;
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL areset_regrant: got %b want 0010", gnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] r    = 4'b0;
    logic [3:0] prev = 4'b0;
    logic       bad;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r);
      n_checks++;
      if ({gnt, bus_busy, preempt} !== {e_gnt, e_gnt != 4'b0, m_pre})
        $display("FAIL rand cyc %0d req=%b: gnt/busy/pre got %b/%b/%b want %b/%b/%b", c, r, gnt, bus_busy, preempt, e_gnt, e_gnt != 4'b0, m_pre);
      else n_pass++;
      if (e_gnt != 4'b0) begin
        n_checks++;
        if (gnt_id !== 2'(m_owner)) $display("FAIL rand_id cyc %0d: got %0d want %0d", c, gnt_id, m_owner);
        else n_pass++;
      end
      bad = !$onehot0(gnt) || (prev != 4'b0 && gnt != 4'b0 && gnt != prev);
      n_checks++;
      if (bad) $display("FAIL rand_exclusive cyc %0d: prev=%b gnt=%b want one-hot0 and no owner swap", c, prev, gnt);
      else n_pass++;
      prev = gnt;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_release();
    test_glitch();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
